// File: rtl/step_seq_pkg.sv
// Shared encodings and default sizes for the step sequencer that drives
// the 9-state digit display FSM.
package step_seq_pkg;

    localparam int NUM_STATES_DEF   = 9;
    localparam int STATE_W_DEF      = 4;
    localparam int WAIT_TIMEOUT_DEF = 3;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_SEEK   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        WAIT = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/step_sequencer_btn_sync_edge.sv
// Brings the raw pushbutton into the clk domain and flags its rising edge
// as a single-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/step_sequencer.sv
// Drives the display FSM's step input in manual, auto-run or seek mode and
// confirms each step against the FSM's reported state.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int NUM_STATES   = NUM_STATES_DEF,
    parameter int STATE_W      = STATE_W_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_step,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [STATE_W-1:0] target,
    input  logic [STATE_W-1:0] fsm_state,
    output logic               step_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         step_count
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);
    localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

    ctrl_state_e state_q, state_d;
    mode_e       mode_sel;
    logic        rise, tick, illegal;
    logic [PRESC_W-1:0] presc;
    logic [TMO_W-1:0]   wait_cnt;
    logic [STATE_W-1:0] expected_q, target_q;
    logic seek_q, halted_q, err_q, done_q;
    logic set_err, clr_err, set_done, set_seek, clr_seek, set_halt;

    assign mode_sel = mode_e'(mode);
    assign illegal  = (fsm_state > LAST_STATE);

    btn_sync_edge u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_step),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (mode_sel != MODE_AUTO || presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (mode_sel == MODE_AUTO) && (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        set_err  = 1'b0;
        clr_err  = 1'b0;
        set_done = 1'b0;
        set_seek = 1'b0;
        clr_seek = 1'b0;
        set_halt = 1'b0;
        case (state_q)
            IDLE: begin
                if (illegal) begin
                    set_err  = 1'b1;
                    set_halt = 1'b1;
                end else begin
                    case (mode_sel)
                        MODE_MANUAL: if (rise && !halted_q) state_d = STEP;
                        MODE_AUTO:   if (tick && !halted_q) state_d = STEP;
                        MODE_SEEK: begin
                            if (start) begin
                                if (target > LAST_STATE) begin
                                    set_err = 1'b1;
                                end else if (fsm_state == target) begin
                                    set_done = 1'b1;
                                end else begin
                                    clr_err  = 1'b1;
                                    set_seek = 1'b1;
                                    state_d  = STEP;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            STEP: state_d = WAIT;
            WAIT: begin
                if (illegal) begin
                    set_err  = 1'b1;
                    set_halt = 1'b1;
                    clr_seek = 1'b1;
                    state_d  = IDLE;
                end else if (fsm_state == expected_q) begin
                    // A seek only continues or completes while still in seek mode
                    if (seek_q && mode_sel == MODE_SEEK && expected_q != target_q) begin
                        state_d = STEP;
                    end else begin
                        set_done = seek_q && (mode_sel == MODE_SEEK);
                        clr_seek = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (wait_cnt == TMO_LAST) begin
                    set_err  = 1'b1;
                    clr_seek = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            seek_q     <= 1'b0;
            halted_q   <= 1'b0;
            target_q   <= '0;
            expected_q <= '0;
            wait_cnt   <= '0;
            step_count <= 8'd0;
        end else begin
            done_q <= set_done;
            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
            if (set_halt) begin
                halted_q <= 1'b1;
            end else if (clr_err) begin
                halted_q <= 1'b0;
            end
            if (set_seek) begin
                seek_q   <= 1'b1;
                target_q <= target;
            end else if (clr_seek) begin
                seek_q <= 1'b0;
            end
            if (state_q == STEP) begin
                expected_q <= (fsm_state == LAST_STATE) ? '0 : fsm_state + 1'b1;
                step_count <= step_count + 8'd1;
                wait_cnt   <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign step_out = (state_q == STEP);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Controller that sequences the 9-state digit display FSM (states 0..8, wrapping 8->0) by driving its single-bit step input (data_in).
- Modes: manual single-step from a raw pushbutton, auto-run at a divided rate, and seek-to-target.
- Watches the FSM's current_state feedback to confirm every step and flags a stall or an illegal state.
- Sits between board I/O (button, switches) and the FSM.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per auto-run step (>=2)
- NUM_STATES, 9, number of legal FSM states (0..NUM_STATES-1)
- STATE_W, 4, width of state/target buses
- WAIT_TIMEOUT, 3, cycles allowed for step confirmation

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- btn_step  in  1  raw pushbutton, asynchronous to clk
- mode  in  2  00 manual, 01 auto-run, 10 seek, 11 hold
- start  in  1  single-cycle pulse; begins a seek (only honoured when mode==10)
- target  in  STATE_W  seek destination state
- fsm_state  in  STATE_W  current_state fed back from the FSM
- step_out  out  1  one-cycle pulse to FSM data_in
- busy  out  1  high while a step or seek is in progress
- done  out  1  one-cycle pulse when a seek reaches target
- err  out  1  sticky error flag
- step_count  out  8  steps issued since reset, wraps 255->0

Behaviour:
- Reset (reset==0, asynchronous):
  - Controller state = IDLE.
  - step_out, busy, done, err, step_count all 0.
  - Synchronizer flops and prescaler all 0.
- Button path: 2-flop synchronizer, then a previous-value flop. rise = sync2 & ~prev.
  - btn_step first sampled high at edge E: step_out is high in the cycle after edge E+2.
- Prescaler: counts 0..TICK_DIV-1 only while mode==01. tick is high for one cycle at TICK_DIV-1, then the count returns to 0. In any other mode the prescaler is held at 0.
- Controller states:
  - IDLE (busy=0):
    - mode==00 and rise -> STEP.
    - mode==01 and tick -> STEP.
    - mode==10 and start:
      - target>=NUM_STATES -> err=1, stay IDLE.
      - fsm_state==target -> done pulse, stay IDLE.
      - otherwise clear err, set seek flag -> STEP.
    - mode==11: all requests ignored.
  - STEP (busy=1):
    - step_out=1 for exactly this cycle.
    - Latch expected = (fsm_state==NUM_STATES-1) ? 0 : fsm_state+1.
    - step_count += 1.
    - -> WAIT, timeout counter cleared.
  - WAIT (busy=1):
    - fsm_state==expected:
      - seek flag set, mode==10 and expected!=target -> STEP.
      - seek flag set and expected==target -> done pulse, clear seek flag -> IDLE.
      - otherwise -> IDLE (clear seek flag).
    - No match after WAIT_TIMEOUT cycles -> err=1, clear seek flag -> IDLE.
- Each seek step takes 2 cycles (STEP, WAIT), so N steps reach done 2N cycles after leaving IDLE.
- Wrap: seeking 7->1 issues 3 steps (7->8->0->1).
- Illegal fsm_state (>=NUM_STATES, e.g. 1110) seen in IDLE or WAIT -> err=1, abort to IDLE; no further steps until a valid start.
- err is cleared only by reset or by an accepted start with a valid target.
- Button rises, ticks and start pulses arriving during STEP/WAIT are dropped, not queued.
- mode leaves 10 mid-seek: the in-flight step completes (WAIT resolves), then IDLE, no done.
- start and rise in the same cycle: mode selects which one applies; the other is ignored.
- step_out is never high in two consecutive cycles.

Decomposition:
- Package step_seq_pkg holds:
  - mode encodings: MODE_MANUAL, MODE_AUTO, MODE_SEEK, MODE_HOLD
  - controller state encoding: IDLE, STEP, WAIT
  - NUM_STATES, STATE_W, WAIT_TIMEOUT defaults
- Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge detect, same clk/reset, output rise.

Test Plan:
- Reset mid-WAIT (reset low for 2 cycles, FSM model at 3) -> step_out, busy, done, err, step_count all 0 immediately; IDLE after release.
- mode=00, btn_step high 10 cycles, FSM model at 0 -> exactly one step_out pulse 3 edges after first sample, fsm_state 1, step_count=1; held button gives no second pulse.
- mode=01, TICK_DIV=4, 20 cycles -> step_out every 4 cycles plus confirmation, FSM advances 0->1->2->3..., no err.
- mode=10, FSM at 2, start with target=5 -> 3 step_out pulses 2 cycles apart, done pulse 6 cycles after start, busy low afterwards.
- mode=10, FSM at 7, target=1 -> steps 7->8->0->1, done asserted; target=9 instead -> err=1, no step_out.
- FSM model ignores data_in (stuck at 4) during seek -> err=1 after WAIT_TIMEOUT cycles, busy=0, no done; next valid start clears err.
